// File: rtl/rf_pulse_deframer.sv
// rf_pulse_deframer: RF pulse slot recovery, preamble detect, MSB-first
// deserialiser and DEPTH-entry packet FIFO.
// Optional CRC-8 trailer check (poly 0x07, init 0x00) when RX_CRC_EN is defined.
module rf_pulse_deframer #(
  parameter int unsigned PKT_BITS   = 64,
  parameter int unsigned PRE_BITS   = 8,
  parameter int unsigned BIT_CYCLES = 10000,
  parameter int unsigned TOL_CYCLES = 2500,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESET,
  input  logic                       i_rfin,
  input  logic                       i_rd_en,
  input  logic                       i_clr_ovf,
  output logic                       o_pkt_rec,
  output logic [PKT_BITS-1:0]        o_rd_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf,
`ifdef RX_CRC_EN
  output logic                       o_crc_err,
`endif
  output logic                       o_busy
);

  localparam int unsigned CNT_W  = $clog2(BIT_CYCLES);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned PRE_W  = $clog2(PRE_BITS + 1);
  localparam int unsigned BIT_W  = $clog2(PKT_BITS + 1);
  localparam int unsigned HALF   = BIT_CYCLES / 2;
  localparam int unsigned WIN_LO = HALF - TOL_CYCLES;
  localparam int unsigned WIN_HI = HALF + TOL_CYCLES;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic                rfin_s1_q, rfin_s2_q, rfin_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                seen_q, seen_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PKT_BITS-1:0] sr_q, sr_d;
  logic [PKT_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic                empty_q, empty_d, full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                pkt_rec_q, pkt_rec_d;
  logic                busy_q, busy_d;
  logic                edge_c, slot_end_c, in_win_c, push_c, pop_c, crc_ok_c;
`ifdef RX_CRC_EN
  logic [7:0]          crc_q, crc_d;
  logic                crc_err_q, crc_err_d;
  logic                fb_c;
`endif

  assign edge_c     = rfin_s2_q & ~rfin_prev_q;
  assign slot_end_c = (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign in_win_c   = edge_c && (cnt_q >= CNT_W'(WIN_LO)) && (cnt_q <= CNT_W'(WIN_HI));
  assign pop_c      = i_rd_en & ~empty_q;

  // Next-state logic: slot timer, framing FSM, CRC and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    pkt_rec_d = 1'b0;
    push_c    = 1'b0;
    crc_ok_c  = 1'b1;
    ovf_d     = i_clr_ovf ? 1'b0 : ovf_q;
`ifdef RX_CRC_EN
    crc_d     = crc_q;
    crc_err_d = 1'b0;
    fb_c      = crc_q[7] ^ seen_q;
    crc_ok_c  = (crc_q == sr_q[7:0]);
`endif
    // Slot timer runs only while framing; an edge at slot end is never in-window.
    if (state_q == PREAMBLE || state_q == DATA) begin
      if (slot_end_c) begin
        cnt_d  = '0;
        seen_d = 1'b0;
      end else if (in_win_c) begin
        cnt_d  = CNT_W'(HALF);
        seen_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
    case (state_q)
      IDLE: begin
        if (edge_c) begin
          cnt_d     = CNT_W'(HALF);
          seen_d    = 1'b1;
          pre_cnt_d = '0;
          bit_cnt_d = '0;
          sr_d      = '0;
`ifdef RX_CRC_EN
          crc_d     = '0;
`endif
          state_d   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (slot_end_c) begin
          if (!seen_q) begin
            state_d = IDLE;
          end else if (pre_cnt_q == PRE_W'(PRE_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
      end
      DATA: begin
        if (slot_end_c) begin
          sr_d      = {sr_q[PKT_BITS-2:0], seen_q};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
`ifdef RX_CRC_EN
          if (bit_cnt_q < BIT_W'(PKT_BITS - 8))
            crc_d = {crc_q[6:0], 1'b0} ^ (fb_c ? 8'h07 : 8'h00);
`endif
          if (bit_cnt_q == BIT_W'(PKT_BITS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (crc_ok_c) begin
          if (!full_q || i_rd_en) begin
            push_c    = 1'b1;
            pkt_rec_d = 1'b1;
          end else begin
            ovf_d     = 1'b1;
          end
        end else begin
`ifdef RX_CRC_EN
          crc_err_d = 1'b1;
`endif
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + OCC_W'(push_c) - OCC_W'(pop_c);
    empty_d  = (count_d == '0);
    full_d   = (count_d == OCC_W'(DEPTH));
    busy_d   = (state_d != IDLE);
  end

  // State, synchroniser and FIFO registers with synchronous reset.
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q     <= IDLE;
      rfin_s1_q   <= 1'b0;
      rfin_s2_q   <= 1'b0;
      rfin_prev_q <= 1'b0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pkt_rec_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef RX_CRC_EN
      crc_q       <= '0;
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rfin_s1_q   <= i_rfin;
      rfin_s2_q   <= rfin_s1_q;
      rfin_prev_q <= rfin_s2_q;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      pkt_rec_q   <= pkt_rec_d;
      busy_q      <= busy_d;
      if (push_c) mem_q[wr_ptr_q] <= sr_q;
`ifdef RX_CRC_EN
      crc_q       <= crc_d;
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  assign o_pkt_rec = pkt_rec_q;
  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_empty   = empty_q;
  assign o_full    = full_q;
  assign o_count   = count_q;
  assign o_ovf     = ovf_q;
  assign o_busy    = busy_q;
`ifdef RX_CRC_EN
  assign o_crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_rf_pulse_deframer.sv
// Bench for rf_pulse_deframer: random packets sent as timed pulses, checked
// against a queue-based model of framing, FIFO and overflow. Honours RX_CRC_EN.
module tb_rf_pulse_deframer;
  localparam int unsigned PKT = 64;
  localparam int unsigned PRE = 8;
  localparam int unsigned BC  = 100;
  localparam int unsigned TOL = 25;
  localparam int unsigned DEP = 4;
  localparam int          LAT = 53;  // pulse drive edge to its slot-end commit edge

  logic           clk = 1'b0;
  logic           rst, rfin, rd_en, clr_ovf;
  logic           pkt_rec, empty, full, ovf, busy;
  logic [PKT-1:0] rd_data;
  logic [2:0]     count;
`ifdef RX_CRC_EN
  logic           crc_err;
`endif

  rf_pulse_deframer #(.PKT_BITS(PKT), .PRE_BITS(PRE), .BIT_CYCLES(BC),
                      .TOL_CYCLES(TOL), .DEPTH(DEP)) dut (
    .i_PCLK(clk), .i_PRESET(rst), .i_rfin(rfin), .i_rd_en(rd_en),
    .i_clr_ovf(clr_ovf), .o_pkt_rec(pkt_rec), .o_rd_data(rd_data),
    .o_empty(empty), .o_full(full), .o_count(count), .o_ovf(ovf),
`ifdef RX_CRC_EN
    .o_crc_err(crc_err),
`endif
    .o_busy(busy));

  always #5 clk = ~clk;

  int             cyc = 0;
  int             nvec = 0;
  int             nerr = 0;
  int             nrec_seen = 0;
  int             nrec_model = 0;
  logic [PKT-1:0] q[$];
  bit             ovf_m = 1'b0;
  bit             slots[$];

  // Independent pulse counter over the whole run.
  always @(posedge clk) if (pkt_rec === 1'b1) nrec_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PKT-1:0] obs, input logic [PKT-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) chk("schedule", PKT'(cyc), PKT'(t));
    while (cyc < t) tick();
  endtask

  task automatic pulse();
    rfin = 1'b1; tick(); rfin = 1'b0;
  endtask

  function automatic logic [7:0] crc8(input logic [PKT-1:0] d);
    logic [7:0] c = 8'h00;
    for (int i = PKT - 1; i >= 8; i--) begin
      logic fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [PKT-1:0] fix(input logic [PKT-1:0] x);
`ifdef RX_CRC_EN
    return {x[PKT-1:8], crc8(x)};
`else
    return x;
`endif
  endfunction

  function automatic logic [PKT-1:0] rnd();
    logic [PKT-1:0] x = {$urandom, $urandom};
    return fix(x);
  endfunction

  task automatic build(input logic [PKT-1:0] data, input int npre, input int ndata);
    slots.delete();
    repeat (npre) slots.push_back(1'b1);
    for (int i = 0; i < ndata; i++) slots.push_back(data[PKT-1-i]);
  endtask

  // Pulses re-align the receiver, so each slot centre is measured from the last real pulse.
  task automatic drive_slots(input int jit, input int stray_slot, output int last_e, output int last_i);
    last_e = cyc; last_i = 0;
    for (int i = 0; i < slots.size(); i++) begin
      int base, t, j;
      base = (i == 0) ? cyc : last_e + (i - last_i) * BC;
      if (i == stray_slot && i > 0) begin wait_until(base - 40); pulse(); end
      if (slots[i]) begin
        j = (i == 0 || jit == 0) ? 0 : int'($urandom_range(2 * jit)) - jit;
        t = base + j;
        wait_until(t); pulse();
        last_e = t; last_i = i;
      end
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, ".count"}, PKT'(count), PKT'(q.size()));
    chk({tag, ".empty"}, PKT'(empty), PKT'(q.size() == 0));
    chk({tag, ".full"},  PKT'(full),  PKT'(q.size() == DEP));
    if (q.size() > 0) chk({tag, ".head"}, rd_data, q[0]);
  endtask

  task automatic frame(input string tag, input logic [PKT-1:0] data, input int jit,
                       input int stray, input bit popdone, input bit clrdone);
    int le, li, done_e;
    bit ok, acc;
    build(data, PRE, PKT);
    drive_slots(jit, stray, le, li);
    done_e = le + LAT + (slots.size() - 1 - li) * BC;
    wait_until(done_e);
    chk({tag, ".busy_done"}, PKT'(busy), PKT'(1));
    if (popdone && q.size() > 0) chk({tag, ".pophead"}, rd_data, q[0]);
    rd_en = popdone; clr_ovf = clrdone;
    tick();
    rd_en = 1'b0; clr_ovf = 1'b0;
`ifdef RX_CRC_EN
    ok = (crc8(data) == data[7:0]);
`else
    ok = 1'b1;
`endif
    acc = ok && (q.size() < DEP || popdone);
    if (popdone && q.size() > 0) void'(q.pop_front());
    if (acc) begin q.push_back(data); nrec_model++; end
    if (clrdone) ovf_m = 1'b0;
    if (ok && !acc) ovf_m = 1'b1;
    chk({tag, ".pkt_rec"}, PKT'(pkt_rec), PKT'(acc));
    chk({tag, ".ovf"}, PKT'(ovf), PKT'(ovf_m));
    chk({tag, ".busy_after"}, PKT'(busy), PKT'(0));
`ifdef RX_CRC_EN
    chk({tag, ".crc_err"}, PKT'(crc_err), PKT'(!ok));
`endif
    check_fifo(tag);
    tick();
    chk({tag, ".pkt_rec_1cyc"}, PKT'(pkt_rec), PKT'(0));
`ifdef RX_CRC_EN
    chk({tag, ".crc_err_1cyc"}, PKT'(crc_err), PKT'(0));
`endif
    repeat (20) tick();
  endtask

  task automatic pop(input string tag);
    chk({tag, ".data"}, rd_data, q[0]);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    void'(q.pop_front());
    check_fifo(tag);
  endtask

  initial begin
    int le, li, ab_e;
    logic [PKT-1:0] d;
    rst = 1'b1; rfin = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    chk("rst.busy", PKT'(busy), PKT'(0));
    chk("rst.ovf", PKT'(ovf), PKT'(0));
    chk("rst.pkt_rec", PKT'(pkt_rec), PKT'(0));
    chk("rst.rd_data", rd_data, PKT'(0));
    check_fifo("rst");
    rst = 1'b0;
    repeat (5) tick();

    // Clean frame, then jittered copy with a stray pulse.
    frame("t1", fix(64'h8123456789ABCD0F), 0, -1, 1'b0, 1'b0);
    frame("t2", fix(64'h8123456789ABCD0F), 20, 20, 1'b0, 1'b0);

    // Short preamble followed by an empty slot must drop back to idle.
    build(64'h0, 5, 0); slots.push_back(1'b0);
    drive_slots(0, -1, le, li);
    ab_e = le + LAT + (slots.size() - 1 - li) * BC;
    wait_until(ab_e - 1);
    chk("abort.busy_pre", PKT'(busy), PKT'(1));
    tick();
    chk("abort.busy", PKT'(busy), PKT'(0));
    chk("abort.pkt_rec", PKT'(pkt_rec), PKT'(0));
    check_fifo("abort");
    repeat (50) tick();
    frame("t3", fix(64'h0000000000000001), 0, -1, 1'b0, 1'b0);

`ifdef RX_CRC_EN
    d = rnd();
    frame("crc_good", d, 5, -1, 1'b0, 1'b0);
    frame("crc_bad", d ^ (64'h1 << 40), 5, -1, 1'b0, 1'b0);
`endif

    // Fill to full, overflow with a same-cycle clear (set must win), then pop+push.
    for (int g = 0; g < 6 && q.size() < DEP; g++) frame("fill", rnd(), 10, -1, 1'b0, 1'b0);
    chk("fill.full", PKT'(full), PKT'(1));
    frame("ovf", rnd(), 10, -1, 1'b0, 1'b1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; ovf_m = 1'b0;
    chk("clr_ovf", PKT'(ovf), PKT'(0));
    frame("popush", rnd(), 10, -1, 1'b1, 1'b0);
    while (q.size() > 0) pop("drain");
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_fifo("pop_empty");

    // Reset in the middle of data bit 30 discards everything.
    d = rnd();
    frame("pre_rst", rnd(), 0, -1, 1'b0, 1'b0);
    build(d, PRE, 31);
    drive_slots(0, -1, le, li);
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete(); ovf_m = 1'b0;
    chk("midrst.busy", PKT'(busy), PKT'(0));
    chk("midrst.ovf", PKT'(ovf), PKT'(0));
    chk("midrst.rd_data", rd_data, PKT'(0));
    check_fifo("midrst");
    repeat (20) tick();
    frame("post_rst", rnd(), 15, -1, 1'b0, 1'b0);
    pop("post_rst_pop");

    chk("pkt_rec_total", PKT'(nrec_seen), PKT'(nrec_model));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
